// File: rtl/rx_frame_assembler_pkg.sv
// Shared constants for the receive frame assembler: decoder frame geometry,
// per-rate frame lengths and the decoder handshake state encoding.
package rx_frame_assembler_pkg;

  // Decoder frame port width.
  localparam int DEC_FRAME_W = 16;

  // Width of the shift-stage bit counter (holds 0..16).
  localparam int CNT_BITS = 5;

  // Frame lengths in coded bits.
  localparam logic [CNT_BITS-1:0] LEN_R12 = 5'd16;  // rate 1/2
  localparam logic [CNT_BITS-1:0] LEN_R13 = 5'd15;  // rate 1/3

  // Decoder handshake states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Frame length selected by the code-rate input (0 = 1/2, 1 = 1/3).
  function automatic logic [CNT_BITS-1:0] frame_len(input logic code_rate);
    return code_rate ? LEN_R13 : LEN_R12;
  endfunction

endpackage

// File: rtl/rx_frame_assembler_bit_packer.sv
// Shift stage of the receive frame assembler. Packs coded bits MSB-first
// into a frame of LEN bits (LEN latched on the first bit), pads with zeros
// on flush, and reports when a complete frame is available for hand-off.
module rx_frame_assembler_bit_packer
  import rx_frame_assembler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   code_rate,
  input  logic                   data_bit,
  input  logic                   valid,
  input  logic                   flush,
  input  logic                   clear,
  output logic                   ready,
  output logic                   avail,
  output logic                   busy,
  output logic [DEC_FRAME_W-1:0] frame_next
);

  logic [CNT_BITS-1:0]    count;
  logic [CNT_BITS-1:0]    len_q;
  logic [CNT_BITS-1:0]    len_eff;
  logic [CNT_BITS-1:0]    cnt_acc;
  logic [CNT_BITS-1:0]    cnt_nxt;
  logic [DEC_FRAME_W-1:0] sreg;
  logic [3:0]             wr_idx;
  logic                   full_q;
  logic                   accept;

  // A stage holding LEN bits (received or padded) is full and refuses bits.
  // count is never 0 when it equals len_q, since len_q is 15 or 16.
  assign full_q = (count == len_q);
  assign ready  = ~full_q;
  assign accept = valid & ~full_q;
  assign busy   = (count != '0);

  // The length of a new frame comes straight from the rate input; once the
  // first bit is in, the latched value governs and rate changes are ignored.
  assign len_eff = (count == '0) ? frame_len(code_rate) : len_q;
  assign cnt_acc = accept ? (count + CNT_BITS'(1)) : count;

  // A frame may leave this stage when it is already full, or on the very
  // edge its last bit arrives (bypass straight into the hold stage).
  assign avail = full_q | (accept & (cnt_acc == len_eff));

  // Next shift-register contents: the first bit of a frame wipes the old
  // frame so unfilled low bits (and bit 15 at rate 1/3) read as zero.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and no latch is inferred.
    wr_idx     = 4'(len_eff - CNT_BITS'(1) - count);
    frame_next = sreg;
    if (accept) begin
      if (count == '0) begin
        frame_next = '0;
      end
      frame_next[wr_idx] = data_bit;
    end
  end

  // Next bit count: hand-off empties the stage; a flush of a partial frame
  // (after any bit accepted on the same edge) marks it full, zero-padded.
  always_comb begin
    cnt_nxt = cnt_acc;
    if (clear) begin
      cnt_nxt = '0;
    end else if (flush && (cnt_acc != '0) && (cnt_acc < len_eff)) begin
      cnt_nxt = len_eff;
    end
  end

  // Shift-stage state registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      count <= '0;
      len_q <= LEN_R12;
      sreg  <= '0;
    end else begin
      count <= cnt_nxt;
      sreg  <= frame_next;
      if (accept && (count == '0)) begin
        len_q <= len_eff;
      end
    end
  end

endmodule

// File: rtl/rx_frame_assembler.sv
// Receive frame assembler: feeds the Viterbi decoder with 16-bit frames
// packed from a serial coded-bit stream. A shift stage fills the next frame
// while the hold stage presents the current one to the decoder until done.
module rx_frame_assembler
  import rx_frame_assembler_pkg::*;
#(
  parameter int FRAME_W = DEC_FRAME_W,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_code_rate,
  input  logic               i_bit,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_flush,
  input  logic               i_dec_done,
  output logic               o_dec_en,
  output logic [FRAME_W-1:0] o_frame,
  output logic [CNT_W-1:0]   o_frame_cnt,
  output logic               o_busy
);

  logic [DEC_FRAME_W-1:0] frame_next;
  logic [DEC_FRAME_W-1:0] hold;
  logic                   hold_valid;
  logic [0:0]             state;
  logic                   avail;
  logic                   load;
  logic                   pk_busy;
  logic                   run;

  // A ready frame moves to hold only when hold is empty. hold_valid clears
  // on the done edge, so a waiting frame transfers on the edge after done.
  assign load = avail & ~hold_valid;
  assign run  = (state == ST_RUN);

  rx_frame_assembler_bit_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .code_rate  (i_code_rate),
    .data_bit   (i_bit),
    .valid      (i_valid),
    .flush      (i_flush),
    .clear      (load),
    .ready      (o_ready),
    .avail      (avail),
    .busy       (pk_busy),
    .frame_next (frame_next)
  );

  // Hold register: captured only on load, so it stays stable through RUN.
  always_ff @(posedge clk) begin
    // NOTE: hold is reset (not left undefined) because the decoder-facing frame must read zero after reset.
    if (!rst) begin
      hold <= '0;
    end else if (load) begin
      hold <= frame_next;
    end
  end

  // Decoder handshake: enable follows a loaded hold by one cycle and drops,
  // together with hold_valid, on the edge that samples done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      hold_valid <= 1'b0;
    end else begin
      if (load) begin
        hold_valid <= 1'b1;
      end else if (run && i_dec_done) begin
        hold_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: if (hold_valid) state <= ST_RUN;
        ST_RUN:  if (i_dec_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Count of frames handed to the decoder, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_frame_cnt <= '0;
    end else if (load) begin
      o_frame_cnt <= o_frame_cnt + CNT_W'(1);
    end
  end

  assign o_dec_en = run;
  assign o_frame  = FRAME_W'(hold);
  assign o_busy   = pk_busy | hold_valid | run;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Self-checking bench for rx_frame_assembler: directed timing checks plus a
// frame-level reference model feeding a scoreboard checked by a monitor.
module tb_rx_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_code_rate;
  logic        i_bit;
  logic        i_valid;
  logic        i_flush;
  logic        i_dec_done;
  logic        o_ready;
  logic        o_dec_en;
  logic        o_busy;
  logic [15:0] o_frame;
  logic [7:0]  o_frame_cnt;

  always #5 clk = ~clk;

  rx_frame_assembler #(.FRAME_W(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_code_rate (i_code_rate),
    .i_bit       (i_bit),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .i_dec_done  (i_dec_done),
    .o_dec_en    (o_dec_en),
    .o_frame     (o_frame),
    .o_frame_cnt (o_frame_cnt),
    .o_busy      (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: frame = accepted bits read as an MSB-first integer,
  // left-aligned into LEN bits; every closed frame is the next one counted.
  int          m_len    = 16;
  int          m_n      = 0;
  int unsigned m_val    = 0;
  int          m_frames = 0;
  bit          stop     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_close();
    exp_t e;
    e.frame = 16'(m_val << (m_len - m_n));
    m_frames++;
    e.cnt = 8'(m_frames);
    sb_q.push_back(e);
    m_n   = 0;
    m_val = 0;
  endtask

  task automatic m_accept(input logic b, input logic f);
    if (m_n == 0) m_len = i_code_rate ? 15 : 16;
    m_val = (m_val << 1) | 32'(b);
    m_n++;
    if (m_n == m_len) m_close();
    else if (f) m_close();
  endtask

  task automatic m_reset();
    m_n = 0;
    m_val = 0;
    m_frames = 0;
    sb_q.delete();
  endtask

  // Present one bit (optionally with a coincident flush) once ready is seen.
  task automatic send_bit(input logic b, input logic f);
    int w = 0;
    @(negedge clk);
    while (!o_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      check("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    i_valid = 1'b1;
    i_bit   = b;
    i_flush = f;
    @(posedge clk);
    m_accept(b, f);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) send_bit(w[k], 1'b0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    if (m_n > 0) m_close();
    #1;
    i_flush = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    i_dec_done = 1'b1;
    @(posedge clk);
    #1;
    i_dec_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each rising decoder enable must present the next expected
  // frame and count; the frame must then stay constant while enabled.
  logic        prev_en = 1'b0;
  logic [15:0] held    = '0;
  always @(negedge clk) begin
    if (o_dec_en && !prev_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_frame", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_frame", 32'(o_frame), 32'(e.frame));
        check("sb_frame_cnt", 32'(o_frame_cnt), 32'(e.cnt));
      end
      held = o_frame;
    end else if (o_dec_en) begin
      check("frame_stable", 32'(o_frame), 32'(held));
    end
    prev_en = o_dec_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa;
    logic [15:0] wb;
    int          len;
    int          nb;
    int          w;
    bit          coinc;

    rst = 1'b0; i_code_rate = 1'b0; i_bit = 1'b0; i_valid = 1'b0;
    i_flush = 1'b0; i_dec_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dec_en", 32'(o_dec_en), 32'd0);
    check("rst_frame", 32'(o_frame), 32'd0);
    check("rst_cnt", 32'(o_frame_cnt), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rst_ready", 32'(o_ready), 32'd1);

    // 1: rate 1/2 directed frame with bypass into hold
    send_word(16'hB2F1, 16);
    check("t1_frame", 32'(o_frame), 32'hB2F1);
    check("t1_en_low", 32'(o_dec_en), 32'd0);
    check("t1_ready_bypass", 32'(o_ready), 32'd1);
    step();
    check("t1_en_high", 32'(o_dec_en), 32'd1);
    check("t1_cnt", 32'(o_frame_cnt), 32'd1);
    pulse_done();
    check("t1_en_fall", 32'(o_dec_en), 32'd0);
    check("t1_busy", 32'(o_busy), 32'd0);

    // 2: rate 1/3, rate change mid-frame ignored
    i_code_rate = 1'b1;
    for (int k = 0; k < 15; k++) begin
      send_bit(1'b1, 1'b0);
      if (k == 2) i_code_rate = 1'b0;
    end
    check("t2_frame", 32'(o_frame), 32'h7FFF);
    step();
    check("t2_en", 32'(o_dec_en), 32'd1);
    pulse_done();

    // 3: second frame fills during RUN and waits for done
    i_code_rate = 1'b0;
    wa = 16'($urandom);
    wb = 16'($urandom);
    send_word(wa, 16);
    send_word(wb, 16);
    check("t3_ready_full", 32'(o_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_bit   = 1'b1;
      step();
      check("t3_not_accepted", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    pulse_done();
    check("t3_en_fall", 32'(o_dec_en), 32'd0);
    check("t3_still_full", 32'(o_ready), 32'd0);
    step();
    check("t3_load_frame", 32'(o_frame), 32'(wb));
    check("t3_ready_back", 32'(o_ready), 32'd1);
    check("t3_en_low", 32'(o_dec_en), 32'd0);
    step();
    check("t3_en_rise", 32'(o_dec_en), 32'd1);
    check("t3_cnt", 32'(o_frame_cnt), 32'(8'(m_frames)));
    pulse_done();

    // 4: flush padding
    send_word(16'h001B, 5);
    do_flush();
    step();
    check("t4_flush_frame", 32'(o_frame), 32'hD800);
    step();
    pulse_done();
    do_flush();
    step();
    step();
    check("t4_flush_empty_cnt", 32'(o_frame_cnt), 32'(8'(m_frames)));
    check("t4_flush_empty_busy", 32'(o_busy), 32'd0);
    send_word(16'h001B, 5);
    send_bit(1'b1, 1'b1);
    step();
    check("t4_coinc_frame", 32'(o_frame), 32'hDC00);
    step();
    pulse_done();

    // 5: reset during RUN with a partial shift stage
    send_word(16'($urandom), 16);
    for (int k = 0; k < 7; k++) send_bit(1'($urandom), 1'b0);
    check("t5_run", 32'(o_dec_en), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t5_en", 32'(o_dec_en), 32'd0);
    check("t5_frame", 32'(o_frame), 32'd0);
    check("t5_busy", 32'(o_busy), 32'd0);
    check("t5_ready", 32'(o_ready), 32'd1);
    check("t5_cnt", 32'(o_frame_cnt), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    pulse_done();
    step();
    check("t5_done_ignored_en", 32'(o_dec_en), 32'd0);
    check("t5_done_ignored_busy", 32'(o_busy), 32'd0);

    // 6: 256 random frames with an automatic decoder; counter wraps
    fork
      begin
        for (int fr = 0; fr < 256; fr++) begin
          i_code_rate = 1'($urandom_range(0, 1));
          len = i_code_rate ? 15 : 16;
          coinc = 1'b0;
          nb = len;
          if ($urandom_range(0, 3) == 0) begin
            nb = $urandom_range(1, len - 1);
            coinc = 1'($urandom_range(0, 1));
          end
          for (int k = 0; k < nb; k++) begin
            send_bit(1'($urandom), coinc && (k == nb - 1));
            if ($urandom_range(0, 7) == 0) i_code_rate = ~i_code_rate;
          end
          if (nb < len && !coinc) do_flush();
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        w = 0;
        while (o_busy && w < 500) begin
          @(negedge clk);
          w++;
        end
        check("t6_drain", 32'(o_busy), 32'd0);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          if (o_dec_en) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            i_dec_done = 1'b1;
            @(negedge clk);
            i_dec_done = 1'b0;
          end
        end
      end
    join
    check("t6_frames_model", 32'(m_frames), 32'd256);
    check("t6_cnt_wrap", 32'(o_frame_cnt), 32'd0);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    pulse_done();
    step();
    check("t6_stray_done_en", 32'(o_dec_en), 32'd0);
    check("t6_stray_done_busy", 32'(o_busy), 32'd0);
    check("t6_stray_done_cnt", 32'(o_frame_cnt), 32'd0);
    check("t6_stray_done_ready", 32'(o_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
